// File: rtl/val2_pkg.sv
// val2_pkg: shared types, widths and the operand-2 decoder for val2_shifter_pipe
package val2_pkg;
  localparam int WORD_W = 32;
  localparam int SHAMT_W = 8;
  typedef enum logic [1:0] {LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11} shift_type_e;
  typedef enum logic [1:0] {MEM, IMM_ROT, SHIFT_IMM, SHIFT_REG} val2_mode_e;
  typedef struct packed {
    val2_mode_e           mode;
    shift_type_e          stype;
    logic [SHAMT_W-1:0]   amt;
    logic                 c;
    logic [WORD_W-1:0]    opnd;
  } val2_dec_t;
  // Every mode is normalised to operand + type + amount so one barrel shifter serves all.
  function automatic val2_dec_t val2_decode(input logic [WORD_W-1:0] rm, input logic [SHAMT_W-1:0] rs,
                                            input logic imm, input logic mem_en, input logic [11:0] so,
                                            input logic c);
    val2_dec_t d;
    d.mode = SHIFT_REG;
    d.stype = shift_type_e'(so[6:5]);
    d.amt = rs;
    d.c = c;
    d.opnd = rm;
    if (mem_en) begin
      d.mode = MEM;
      d.stype = LSL;
      d.amt = '0;
      d.opnd = {{20{so[11]}}, so};
    end else if (imm) begin
      d.mode = IMM_ROT;
      d.stype = ROR;
      d.amt = {3'b0, so[11:8], 1'b0};
      d.opnd = {24'b0, so[7:0]};
    end else if (!so[4]) begin
      d.mode = SHIFT_IMM;
      d.amt = (so[11:7] == 5'd0 && (so[6:5] == 2'b01 || so[6:5] == 2'b10)) ? 8'd32 : {3'b0, so[11:7]};
    end
    return d;
  endfunction
endpackage

// File: rtl/val2_shift_core.sv
// val2_shift_core: single-cycle barrel shifter for ARM operand 2; carry logic kept only with VAL2_CARRY_OUT_EN
module val2_shift_core
  import val2_pkg::*;
(
  input  val2_dec_t          i_dec,
  output logic [WORD_W-1:0]  o_val2,
  output logic               o_carry
);
  logic [4:0] w_sh;
  logic w_zero, w_32, w_lt32, w_rrx;
  logic [WORD_W:0] w_lsl, w_lsr, w_asr;
  logic [WORD_W-1:0] w_ror;
  assign w_sh = i_dec.amt[4:0];
  assign w_zero = i_dec.amt == '0;
  assign w_32 = i_dec.amt == 8'd32;
  assign w_lt32 = ~|i_dec.amt[7:5];
  assign w_rrx = i_dec.mode == SHIFT_IMM && i_dec.stype == ROR && w_zero;
  // 33-bit shifts leave the last bit shifted out next to the result
  assign w_lsl = {1'b0, i_dec.opnd} << w_sh;
  assign w_lsr = {i_dec.opnd, 1'b0} >> w_sh;
  assign w_asr = $signed({i_dec.opnd, 1'b0}) >>> w_sh;
  assign w_ror = (i_dec.opnd >> w_sh) | (i_dec.opnd << (6'd32 - {1'b0, w_sh}));
  always_comb begin
    o_val2 = i_dec.opnd;
    o_carry = i_dec.c;
    if (w_rrx) begin
      o_val2 = {i_dec.c, i_dec.opnd[31:1]};
      o_carry = i_dec.opnd[0];
    end else if (!w_zero) begin
      case (i_dec.stype)
        LSL: begin
          o_val2 = w_lt32 ? w_lsl[31:0] : '0;
          o_carry = w_lt32 ? w_lsl[32] : w_32 & i_dec.opnd[0];
        end
        LSR: begin
          o_val2 = w_lt32 ? w_lsr[32:1] : '0;
          o_carry = w_lt32 ? w_lsr[0] : w_32 & i_dec.opnd[31];
        end
        ASR: begin
          o_val2 = w_lt32 ? w_asr[32:1] : {WORD_W{i_dec.opnd[31]}};
          o_carry = w_lt32 ? w_asr[0] : i_dec.opnd[31];
        end
        default: begin
          o_val2 = w_ror;
          o_carry = w_ror[31];
        end
      endcase
    end
`ifndef VAL2_CARRY_OUT_EN
    o_carry = i_dec.c;
`endif
  end
endmodule

// File: rtl/val2_shifter_pipe.sv
// val2_shifter_pipe: handshaked 1/2-stage ARM operand-2 pipeline; carry rules enabled by VAL2_CARRY_OUT_EN
module val2_shifter_pipe
  import val2_pkg::*;
#(
  parameter int PIPE_DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  val_Rm,
  input  logic [WORD_W-1:0]  val_Rs,
  input  logic               imm,
  input  logic               mem_en,
  input  logic [11:0]        shift_operand,
  input  logic               carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  val2,
  output logic               carry_out
);
  val2_dec_t w_dec, w_core_in;
  logic [WORD_W-1:0] w_val2;
  logic w_carry, w_out_ld, w_src_v, w_unused_rs;
  logic r_ov, r_carry;
  logic [WORD_W-1:0] r_val2;
  assign w_unused_rs = &{1'b0, val_Rs[WORD_W-1:SHAMT_W]};
  assign w_dec = val2_decode(val_Rm, val_Rs[SHAMT_W-1:0], imm, mem_en, shift_operand, carry_in);
  assign w_out_ld = !r_ov || out_ready;
  val2_shift_core u_core (.i_dec(w_core_in), .o_val2(w_val2), .o_carry(w_carry));
  if (PIPE_DEPTH != 1 && PIPE_DEPTH != 2) begin : g_bad
    $error("val2_shifter_pipe: PIPE_DEPTH must be 1 or 2");
  end
  if (PIPE_DEPTH == 2) begin : g_d2
    val2_dec_t r_dec;
    logic r_v1, w_s1_ld;
    assign w_s1_ld = !r_v1 || w_out_ld;
    assign in_ready = w_s1_ld && !flush;
    assign w_core_in = r_dec;
    assign w_src_v = r_v1;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v1 <= 1'b0;
        r_dec <= '0;
      end else if (flush) begin
        r_v1 <= 1'b0;
      end else if (w_s1_ld) begin
        r_v1 <= in_valid;
        if (in_valid) r_dec <= w_dec;
      end
    end
  end else begin : g_d1
    assign in_ready = w_out_ld && !flush;
    assign w_core_in = w_dec;
    assign w_src_v = in_valid;
  end
  // Output stage: holds while the consumer stalls; flush drops it regardless of out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov <= 1'b0;
      r_val2 <= '0;
      r_carry <= 1'b0;
    end else if (flush) begin
      r_ov <= 1'b0;
    end else if (w_out_ld) begin
      r_ov <= w_src_v;
      if (w_src_v) begin
        r_val2 <= w_val2;
        r_carry <= w_carry;
      end
    end
  end
  assign out_valid = r_ov;
  assign val2 = r_val2;
  assign carry_out = r_carry;
endmodule

// File: tb/tb_val2_shifter_pipe.sv
// tb_val2_shifter_pipe: directed self-checking bench for val2_shifter_pipe at PIPE_DEPTH 2
module tb_val2_shifter_pipe;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst, flush, in_valid, in_ready, imm, mem_en, carry_in, out_valid, out_ready, carry_out;
  logic [31:0] val_Rm, val_Rs, val2;
  logic [11:0] shift_operand;
  int n_chk = 0, n_pass = 0;

  val2_shifter_pipe #(.PIPE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .val_Rm(val_Rm), .val_Rs(val_Rs), .imm(imm), .mem_en(mem_en), .shift_operand(shift_operand),
    .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready), .val2(val2), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic ecar(input logic rule, input logic c);
`ifdef VAL2_CARRY_OUT_EN
    return rule;
`else
    return c;
`endif
  endfunction

  task automatic op(input string tag, input logic [31:0] rm, input logic [31:0] rs, input logic im,
                    input logic me, input logic [11:0] so, input logic c, input logic [31:0] ev, input logic ec);
    int k, lat;
    val_Rm = rm; val_Rs = rs; imm = im; mem_en = me; shift_operand = so; carry_in = c;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 10) begin @(posedge clk); #2; k++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin @(posedge clk); #2; lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(DEPTH));
    chk({tag, " val2"}, val2, ev);
    chk({tag, " carry"}, {31'b0, carry_out}, {31'b0, ecar(ec, c)});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_v [8];
    logic exp_c [8];
    int sent, recv, cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; imm = 1'b0; mem_en = 1'b0;
    carry_in = 1'b0; val_Rm = '0; val_Rs = '0; shift_operand = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset val2", val2, 32'd0);
    chk("reset carry", {31'b0, carry_out}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    op("imm rot8",       32'h0,          32'h0,   1, 0, 12'h4FF, 0, 32'hFF000000, 1);
    op("imm rot0 c1",    32'h0,          32'h0,   1, 0, 12'h0AB, 1, 32'h000000AB, 1);
    op("imm rot0 c0",    32'h0,          32'h0,   1, 0, 12'h0AB, 0, 32'h000000AB, 0);
    op("reg lsr 32",     32'h80000001,   32'd32,  0, 0, 12'h030, 0, 32'h0,        1);
    op("reg lsr 33",     32'h80000001,   32'd33,  0, 0, 12'h030, 1, 32'h0,        0);
    op("reg lsr 0",      32'h80000001,   32'd0,   0, 0, 12'h030, 1, 32'h80000001, 1);
    op("reg lsr rs hi",  32'h80000001,   32'h120, 0, 0, 12'h030, 0, 32'h0,        1);
    op("imm rrx",        32'h00000003,   32'h0,   0, 0, 12'h060, 1, 32'h80000001, 1);
    op("imm asr 0",      32'h80000000,   32'h0,   0, 0, 12'h040, 0, 32'hFFFFFFFF, 1);
    op("imm lsr 0",      32'h80000000,   32'h0,   0, 0, 12'h020, 0, 32'h0,        1);
    op("imm lsl 4",      32'hF000000F,   32'h0,   0, 0, 12'h200, 0, 32'h000000F0, 1);
    op("mem c1",         32'h12345678,   32'h0,   1, 1, 12'hFFC, 1, 32'hFFFFFFFC, 1);
    op("mem c0",         32'h12345678,   32'h0,   0, 1, 12'hFFC, 0, 32'hFFFFFFFC, 0);
    op("reg lsl 32",     32'h00000001,   32'd32,  0, 0, 12'h010, 0, 32'h0,        1);
    op("reg lsl 40",     32'h00000001,   32'd40,  0, 0, 12'h010, 1, 32'h0,        0);
    op("reg ror 32",     32'h80000000,   32'd32,  0, 0, 12'h070, 0, 32'h80000000, 1);
    op("reg ror 4",      32'h0000001F,   32'd4,   0, 0, 12'h070, 0, 32'hF0000001, 1);
    op("reg asr 40",     32'h7FFFFFFF,   32'd40,  0, 0, 12'h050, 1, 32'h0,        0);
    op("reg asr 1",      32'h80000003,   32'd1,   0, 0, 12'h050, 0, 32'hC0000001, 1);

    // Stream of 8 with a 3-cycle consumer stall; stalled cycles must still show the head item
    for (int i = 0; i < 8; i++) begin
      exp_v[i] = 32'(i * 17 + 1);
      exp_c[i] = 1'(i % 2);
    end
    sent = 0; recv = 0; cyc = 0;
    imm = 1'b1; mem_en = 1'b0;
    while (recv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = sent < 8;
      shift_operand = {4'h0, 8'(sent * 17 + 1)};
      carry_in = 1'(sent % 2);
      #1;
      if (out_valid) begin
        chk($sformatf("stream val2 %0d", recv), val2, exp_v[recv]);
        chk($sformatf("stream carry %0d", recv), {31'b0, carry_out}, {31'b0, exp_c[recv]});
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream received", 32'(recv), 32'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("stream no dup", {31'b0, out_valid}, 32'd0);

    // Flush with two in flight and a new request offered
    imm = 1'b1; shift_operand = 12'h011; carry_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    shift_operand = 12'h022;
    @(posedge clk); #1;
    chk("pre-flush out_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1; flush = 1'b1; shift_operand = 12'h033;
    #1;
    chk("flush in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush not accepted", {31'b0, out_valid}, 32'd0);

    // Same stimulus with reset instead of flush
    shift_operand = 12'h011; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    shift_operand = 12'h022;
    @(posedge clk); #1;
    chk("pre-rst out_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1; rst = 1'b1; shift_operand = 12'h033;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst val2", val2, 32'd0);
    chk("rst carry", {31'b0, carry_out}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst not accepted", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/val2_shifter_pipe.md
# val2_shifter_pipe

Pipelined, handshaked successor to the combinational Val2 generator in the EXE stage. Computes the ARM second ALU operand and shifter carry-out in one or two pipeline stages with valid/ready flow control and flush. Adds register-specified shifts (amount from Rs[7:0]), RRX, and the full ARM boundary rules for shift amounts 0, 32 and greater than 32. Sits between the ID/EX register and the ALU.

## Interface
- PIPE_DEPTH, 1, register stages between accept and result; legal values are 1 or 2 (elaboration error otherwise).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drops all in-flight operations (branch taken).
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- val_Rm  in  32  Rm operand.
- val_Rs  in  32  Rs operand; only [7:0] is used.
- imm  in  1  immediate operand (I bit).
- mem_en  in  1  load/store offset mode.
- shift_operand  in  12  instruction bits [11:0].
- carry_in  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- val2  out  32  operand 2.
- carry_out  out  1  shifter carry-out.

## Operation
Mode priority: mem_en, then imm, then shift_operand[4] (register shift), else immediate shift. Shift type t = shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. C = carry_in.
- mem_en: val2 = sign-extended shift_operand; carry = C.
- imm: val2 = zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8]. carry = C when the rotate field is 0, else val2[31].
- Immediate shift, n = shift_operand[11:7]:
  - LSL #0 gives Rm, C.
  - LSR #0 and ASR #0 mean a shift of 32.
  - ROR #0 is RRX: {C, Rm[31:1]}, carry Rm[0].
- Register shift, n = val_Rs[7:0]:
  - n = 0 (any type): Rm, carry C.
  - LSL: n = 1..31 gives Rm<<n, carry Rm[32-n]; n = 32 gives 0, carry Rm[0]; n > 32 gives 0, carry 0.
  - LSR: n = 1..31 gives Rm>>n, carry Rm[n-1]; n = 32 gives 0, carry Rm[31]; n > 32 gives 0, carry 0.
  - ASR: n = 1..31 gives an arithmetic shift, carry Rm[n-1]; n ≥ 32 gives all bits = Rm[31], carry Rm[31].
  - ROR: n[4:0] = 0 gives Rm, carry Rm[31]; otherwise rotate by n[4:0], carry Rm[n[4:0]-1].
- Shift and rotate are single-cycle barrel logic. No iterative loops.

## Timing
- Latency PIPE_DEPTH cycles from accept to out_valid. Throughput is 1 per cycle when out_ready is held high.
- PIPE_DEPTH = 2 splits the work: stage 1 registers decoded mode, type, effective amount and special-case flags; stage 2 registers val2 and carry.
- Each stage loads when it is empty or its content leaves this cycle. in_ready = stage-1 loadable && !flush.
- While out_valid && !out_ready: val2, carry_out and out_valid hold stable and upstream stalls.
- flush: all valid bits clear next cycle, and an input presented in the same cycle is not accepted. flush overrides out_ready.
- rst (including mid-operation): all valid bits 0, val2 = 0, carry_out = 0, stage data = 0. in_ready is 1 from the first cycle after rst deasserts.
- out_valid never rises without a prior accepted request.

## Configuration
- VAL2_CARRY_OUT_EN defined: carry_out follows the rules above.
- VAL2_CARRY_OUT_EN undefined: carry-out logic is removed and carry_out is the registered carry_in of the same operation. val2 is unchanged.

## Structure
- Shared package val2_pkg:
  - shift_type_e enum (LSL, LSR, ASR, ROR);
  - val2_mode_e enum (MEM, IMM_ROT, SHIFT_IMM, SHIFT_REG);
  - packed struct val2_dec_t for the stage-1 payload;
  - constants WORD_W = 32 and SHAMT_W = 8.
- One combinational sub-module, val2_shift_core (decoded inputs → val2, carry), is instantiated once. It is shared by both depths; only the register placement differs.

## Test plan
- imm=1, shift_operand=0x4FF, C=0 → val2 0xFF000000, carry 1, out_valid exactly PIPE_DEPTH cycles after accept.
- Register LSR, Rm=0x80000001, Rs=32 → val2 0, carry 1. Rs=33 → val2 0, carry 0. Rs=0, C=1 → val2 0x80000001, carry 1.
- Immediate ROR #0 (RRX), Rm=0x00000003, C=1 → val2 0x80000001, carry 1. ASR #0 with Rm=0x80000000 → 0xFFFFFFFF, carry 1.
- mem_en, shift_operand=0xFFC → val2 0xFFFFFFFC, carry = C.
- Back-to-back stream of 8 requests, out_ready low for 3 cycles mid-stream → no loss or duplication, order preserved, outputs stable while stalled.
- flush asserted with 2 requests in flight plus in_valid high → out_valid 0 next cycle, in_ready 0 that cycle, the new request is not accepted. Repeat the same stimulus with rst instead of flush → all outputs 0.
